// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared constants and types for the ATM transaction front-end
package atm_pkg;

    localparam int AMT_W      = 8;
    localparam int PIN_DIGITS = 4;
    localparam int PIN_W      = 4 * PIN_DIGITS;

    // Session states, kept as plain constants so older tools see a fixed encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_PIN    = 3'd1;
    localparam state_t ST_MENU   = 3'd2;
    localparam state_t ST_AMOUNT = 3'd3;
    localparam state_t ST_ISSUE  = 3'd4;
    localparam state_t ST_WAIT   = 3'd5;
    localparam state_t ST_LOCKED = 3'd6;

    typedef enum logic {
        OP_DEP = 1'b0,
        OP_WDR = 1'b1
    } op_e;

endpackage

// File: rtl/atm_idle_timer.sv
// rtl/atm_idle_timer.sv - idle-cycle counter that fires once after TIMEOUT quiet cycles
module atm_idle_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    localparam int             W    = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0]   LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    // The tick that would make the count reach TIMEOUT is the expiry tick
    assign expire = tick && (cnt == LAST);

    // Count quiet cycles; any clear or the expiry itself restarts from zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || expire) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/atm_txn_ctrl.sv
// rtl/atm_txn_ctrl.sv - PIN session, request pre-check and balance counter initiator
module atm_txn_ctrl
    import atm_pkg::*;
#(
    parameter logic [15:0] PIN_CODE  = 16'h1234,
    parameter int          MAX_TRIES = 3,
    parameter int          TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             card_in,
    input  logic             key_valid,
    input  logic [3:0]       key_digit,
    input  logic             op_dep,
    input  logic             op_wdr,
    input  logic [AMT_W-1:0] amount_in,
    input  logic             confirm,
    input  logic             cancel,
    input  logic [AMT_W-1:0] count,
    output logic             inc,
    output logic             dec,
    output logic [AMT_W-1:0] amount,
    output logic             txn_ok,
    output logic             txn_rej,
    output logic             txn_err,
    output logic             timeout,
    output logic             locked,
    output logic             pin_bad
);

    localparam int               TRY_W   = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);
    localparam logic [2:0]       LAST_DIGIT = 3'(PIN_DIGITS - 1);
    localparam logic [AMT_W:0]   AMT_MAX = {1'b0, {AMT_W{1'b1}}};

    state_t             state;
    // Only the earlier digits are stored; the newest digit completes the code in-flight
    logic [PIN_W-5:0]   pin_sr;
    logic [2:0]         digits;
    logic [TRY_W-1:0]   tries;
    op_e                op_q;
    logic [AMT_W-1:0]   amt_q;
    logic [AMT_W-1:0]   bal_q;

    logic               active;
    logic               strobe;
    logic               abort;
    logic [PIN_W-1:0]   pin_next;
    logic [TRY_W-1:0]   tries_inc;
    logic               reject;
    logic [AMT_W-1:0]   exp_bal;
    logic               timer_expire;

    assign active    = (state == ST_PIN) || (state == ST_MENU) || (state == ST_AMOUNT);
    assign strobe    = key_valid || op_dep || op_wdr || confirm;
    assign abort     = active && (!card_in || cancel);
    assign pin_next  = {pin_sr, key_digit};
    assign tries_inc = tries + 1'b1;
    assign exp_bal   = (op_q == OP_DEP) ? bal_q + amt_q : bal_q - amt_q;

    // Pre-check of the confirmed request against the balance seen in the same cycle
    always_comb begin
        reject = 1'b0;
        if (amount_in == '0) begin
            reject = 1'b1;
        end else if (op_q == OP_WDR) begin
            reject = amount_in > count;
        end else begin
            reject = ({1'b0, count} + {1'b0, amount_in}) > AMT_MAX;
        end
    end

    atm_idle_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!active || strobe),
        .tick   (active && !strobe),
        .expire (timer_expire)
    );

    // Session FSM with registered request and status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            pin_sr  <= '0;
            digits  <= '0;
            tries   <= '0;
            op_q    <= OP_DEP;
            amt_q   <= '0;
            bal_q   <= '0;
            inc     <= 1'b0;
            dec     <= 1'b0;
            amount  <= '0;
            txn_ok  <= 1'b0;
            txn_rej <= 1'b0;
            txn_err <= 1'b0;
            timeout <= 1'b0;
            locked  <= 1'b0;
            pin_bad <= 1'b0;
        end else begin
            inc     <= 1'b0;
            dec     <= 1'b0;
            txn_ok  <= 1'b0;
            txn_rej <= 1'b0;
            txn_err <= 1'b0;
            timeout <= 1'b0;
            pin_bad <= 1'b0;
            case (state)
                ST_IDLE: begin
                    digits <= '0;
                    if (card_in) state <= ST_PIN;
                end
                ST_PIN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (key_valid) begin
                        pin_sr <= pin_next[PIN_W-5:0];
                        if (digits == LAST_DIGIT) begin
                            digits <= '0;
                            if (pin_next == PIN_CODE) begin
                                tries <= '0;
                                state <= ST_MENU;
                            end else begin
                                pin_bad <= 1'b1;
                                tries   <= tries_inc;
                                if (tries_inc == TRY_MAX) begin
                                    state  <= ST_LOCKED;
                                    locked <= 1'b1;
                                end
                            end
                        end else begin
                            digits <= digits + 1'b1;
                        end
                    end else if (timer_expire) begin
                        timeout <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                ST_MENU: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (op_dep) begin
                        op_q  <= OP_DEP;
                        state <= ST_AMOUNT;
                    end else if (op_wdr) begin
                        op_q  <= OP_WDR;
                        state <= ST_AMOUNT;
                    end else if (timer_expire) begin
                        timeout <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                ST_AMOUNT: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (confirm) begin
                        amt_q <= amount_in;
                        bal_q <= count;
                        if (reject) begin
                            txn_rej <= 1'b1;
                            state   <= ST_MENU;
                        end else begin
                            amount <= amount_in;
                            inc    <= (op_q == OP_DEP);
                            dec    <= (op_q == OP_WDR);
                            state  <= ST_ISSUE;
                        end
                    end else if (timer_expire) begin
                        timeout <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    txn_ok  <= (count == exp_bal);
                    txn_err <= (count != exp_bal);
                    state   <= card_in ? ST_MENU : ST_IDLE;
                end
                ST_LOCKED: begin
                    locked <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atm_txn_ctrl.sv
// tb/tb_atm_txn_ctrl.sv - randomized self-checking bench for atm_txn_ctrl
module tb_atm_txn_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       card_in, key_valid, op_dep, op_wdr, confirm, cancel;
    logic [3:0] key_digit;
    logic [7:0] amount_in;
    logic       inc, dec, txn_ok, txn_rej, txn_err, timeout, locked, pin_bad;
    logic [7:0] amount;

    // Behavioural balance counter: updates on the edge after inc/dec
    logic [7:0] cnt_q = 8'd0;
    logic       preset_en = 1'b0;
    logic [7:0] preset_val = 8'd0;
    logic       corrupt = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_inc = 0, n_dec = 0, n_ok = 0, n_rej = 0, n_err = 0, n_to = 0, n_bad = 0, n_both = 0;
    logic [7:0] last_amt = 8'd0;
    int m_bal = 0;

    always #5 clk = ~clk;

    atm_txn_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .card_in   (card_in),
        .key_valid (key_valid),
        .key_digit (key_digit),
        .op_dep    (op_dep),
        .op_wdr    (op_wdr),
        .amount_in (amount_in),
        .confirm   (confirm),
        .cancel    (cancel),
        .count     (cnt_q),
        .inc       (inc),
        .dec       (dec),
        .amount    (amount),
        .txn_ok    (txn_ok),
        .txn_rej   (txn_rej),
        .txn_err   (txn_err),
        .timeout   (timeout),
        .locked    (locked),
        .pin_bad   (pin_bad)
    );

    always @(posedge clk) begin
        if (preset_en)  cnt_q <= preset_val;
        else if (inc)   cnt_q <= cnt_q + amount + {7'd0, corrupt};
        else if (dec)   cnt_q <= cnt_q - amount + {7'd0, corrupt};
    end

    always @(negedge clk) begin
        if (inc)            n_inc  <= n_inc + 1;
        if (dec)            n_dec  <= n_dec + 1;
        if (inc && dec)     n_both <= n_both + 1;
        if (txn_ok)         n_ok   <= n_ok + 1;
        if (txn_rej)        n_rej  <= n_rej + 1;
        if (txn_err)        n_err  <= n_err + 1;
        if (timeout)        n_to   <= n_to + 1;
        if (pin_bad)        n_bad  <= n_bad + 1;
        if (inc || dec)     last_amt <= amount;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preset(input int v);
        preset_val = v[7:0];
        preset_en  = 1'b1;
        step();
        preset_en  = 1'b0;
        m_bal      = v;
    endtask

    task automatic press_key(input logic [3:0] d);
        key_digit = d;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    task automatic enter_pin(input logic [15:0] p);
        for (int i = 0; i < 4; i++) press_key(p[15-4*i -: 4]);
    endtask

    task automatic reinsert();
        card_in = 1'b0;
        step();
        card_in = 1'b1;
        step();
    endtask

    task automatic login();
        reinsert();
        enter_pin(16'h1234);
    endtask

    task automatic strobe_op(input bit dep);
        op_dep = dep;
        op_wdr = !dep;
        step();
        op_dep = 1'b0;
        op_wdr = 1'b0;
    endtask

    task automatic strobe_confirm(input int amt);
        amount_in = amt[7:0];
        confirm   = 1'b1;
        step();
        confirm   = 1'b0;
    endtask

    // One MENU-state transaction, predicted from the pre-check rules
    task automatic run_txn(input bit dep, input bit both, input int amt, input bit bad);
        int  b0, i0, d0, o0, r0, e0, nb;
        bit  is_dep, rej;
        b0 = m_bal; i0 = n_inc; d0 = n_dec; o0 = n_ok; r0 = n_rej; e0 = n_err;
        is_dep = dep || both;
        corrupt = bad;
        repeat ($urandom_range(0, 2)) step();
        op_dep = dep || both;
        op_wdr = !dep || both;
        step();
        op_dep = 1'b0;
        op_wdr = 1'b0;
        repeat ($urandom_range(0, 2)) step();
        strobe_confirm(amt);
        repeat (4) step();
        corrupt = 1'b0;
        rej = (amt == 0) || (!is_dep && amt > b0) || (is_dep && b0 + amt > 255);
        if (rej) begin
            check("rej_pulse", n_rej - r0, 1);
            check("rej_noreq", (n_inc - i0) + (n_dec - d0), 0);
            check("rej_nostat", (n_ok - o0) + (n_err - e0), 0);
        end else begin
            check("req_inc", n_inc - i0, is_dep);
            check("req_dec", n_dec - d0, !is_dep);
            check("req_amt", last_amt, amt);
            check("stat_ok", n_ok - o0, !bad);
            check("stat_err", n_err - e0, bad);
            nb = is_dep ? b0 + amt : b0 - amt;
            if (bad) nb = nb + 1;
            m_bal = nb & 255;
        end
        check("balance", cnt_q, m_bal);
    endtask

    initial begin
        int i0, o0, t0, b0, amt, mode;
        bit dep;
        rst = 1'b0; card_in = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
        op_dep = 1'b0; op_wdr = 1'b0; amount_in = 8'd0; confirm = 1'b0; cancel = 1'b0;
        repeat (3) step();
        check("rst_outs", {inc, dec, txn_ok, txn_rej, txn_err, timeout, locked, pin_bad}, 0);
        check("rst_amount", amount, 0);
        rst = 1'b1;
        preset(0);

        // Deposit 100 from zero: request and status latency
        login();
        strobe_op(1'b1);
        amount_in = 8'd100;
        confirm = 1'b1;
        step();
        confirm = 1'b0;
        check("lat_inc", inc, 1);
        check("lat_dec", dec, 0);
        check("lat_amount", amount, 100);
        step();
        check("lat_inc_drop", inc, 0);
        check("lat_no_early_ok", txn_ok, 0);
        check("lat_count", cnt_q, 100);
        step();
        check("lat_ok", txn_ok, 1);
        step();
        check("lat_ok_drop", txn_ok, 0);
        check("amount_hold", amount, 100);
        m_bal = 100;

        // Boundary cases
        preset(50);
        run_txn(1'b0, 1'b0, 80, 1'b0);
        run_txn(1'b0, 1'b0, 50, 1'b0);
        preset(200);
        run_txn(1'b1, 1'b0, 56, 1'b0);
        run_txn(1'b1, 1'b0, 55, 1'b0);
        run_txn(1'b1, 1'b0, 0, 1'b0);
        preset(20);
        run_txn(1'b0, 1'b1, 10, 1'b0);
        run_txn(1'b1, 1'b0, 5, 1'b1);

        // Randomized transactions biased towards the limits
        for (int k = 0; k < 40; k++) begin
            if (k % 8 == 0) preset($urandom_range(0, 255));
            dep  = $urandom_range(0, 1);
            mode = $urandom_range(0, 3);
            case (mode)
                0:       amt = $urandom_range(0, 255);
                1:       amt = dep ? 255 - m_bal + $urandom_range(0, 1) : m_bal + $urandom_range(0, 1);
                2:       amt = $urandom_range(1, 8);
                default: amt = 0;
            endcase
            if (amt > 255) amt = 255;
            run_txn(dep, 1'b0, amt, ($urandom_range(0, 9) == 0));
        end

        // Card pulled during WAIT: status still issued, then IDLE
        preset(10);
        o0 = n_ok;
        strobe_op(1'b1);
        strobe_confirm(5);
        step();
        card_in = 1'b0;
        step();
        step();
        check("wait_pull_ok", n_ok - o0, 1);
        check("wait_pull_bal", cnt_q, 15);
        i0 = n_inc;
        card_in = 1'b1;
        step();
        strobe_op(1'b1);
        strobe_confirm(5);
        repeat (3) step();
        check("wait_pull_idle", n_inc - i0, 0);

        // Card pulled in AMOUNT: no request
        login();
        i0 = n_inc + n_dec;
        strobe_op(1'b0);
        card_in = 1'b0;
        step();
        card_in = 1'b1;
        step();
        strobe_confirm(5);
        repeat (3) step();
        check("amt_pull_noreq", n_inc + n_dec - i0, 0);

        // Idle timeout in MENU after 255 quiet cycles
        login();
        t0 = n_to;
        repeat (254) step();
        check("to_early", n_to - t0, 0);
        step();
        check("to_pulse", timeout, 1);
        step();
        check("to_drop", timeout, 0);
        i0 = n_inc;
        strobe_op(1'b1);
        strobe_confirm(5);
        repeat (3) step();
        check("to_idle", n_inc - i0, 0);

        // Reset while the request is on the wire
        login();
        preset(0);
        strobe_op(1'b1);
        strobe_confirm(7);
        check("issue_inc", inc, 1);
        rst = 1'b0;
        #1;
        check("rst_inc_drop", inc, 0);
        check("rst_amount_clr", amount, 0);
        repeat (2) step();
        rst = 1'b1;
        check("rst_no_update", cnt_q, 0);

        // A correct PIN clears the try counter
        reinsert();
        enter_pin(16'h0000);
        enter_pin(16'h0000);
        enter_pin(16'h1234);
        reinsert();
        enter_pin(16'h0000);
        enter_pin(16'h0000);
        enter_pin(16'h1234);
        check("tries_clear", locked, 0);
        run_txn(1'b1, 1'b0, 9, 1'b0);

        // Three wrong PINs lock the session until reset
        reinsert();
        b0 = n_bad;
        enter_pin(16'h0000);
        enter_pin(16'h0000);
        enter_pin(16'h0000);
        step();
        check("lock_bad_cnt", n_bad - b0, 3);
        check("lock_level", locked, 1);
        i0 = n_inc + n_ok;
        enter_pin(16'h1234);
        reinsert();
        enter_pin(16'h1234);
        strobe_op(1'b1);
        strobe_confirm(5);
        repeat (3) step();
        check("lock_ignores", n_inc + n_ok - i0, 0);
        check("lock_hold", locked, 1);
        rst = 1'b0;
        #1;
        check("lock_reset", locked, 0);
        repeat (2) step();
        rst = 1'b1;

        check("never_both", n_both, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
